mem_bus_controller: RTL

MEM_BUS_CONTROLLER -- requirements
Module: mem_bus_controller

---
 rtl/mem_bus_controller_if.sv | 26 ++
 rtl/mem_bus_controller.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_controller_if.sv
// CPU-side request/response bus of the memory bus controller.
// valid/ready: a request is taken on a rising edge where req_read|req_write is high and req_ready is high; resp_valid is a one-cycle completion pulse.
interface mem_bus_controller_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic                  req_read;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [1:0]            req_size;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  req_ready;
  logic                  resp_valid;
  logic                  resp_fault;
  logic [DATA_WIDTH-1:0] resp_rdata;

  modport master (
    output req_read, req_write, req_addr, req_size, req_wdata,
    input  req_ready, resp_valid, resp_fault, resp_rdata
  );

  modport slave (
    input  req_read, req_write, req_addr, req_size, req_wdata,
    output req_ready, resp_valid, resp_fault, resp_rdata
  );
endinterface

// File: rtl/mem_bus_controller.sv
// Single-outstanding CPU bus controller routing byte-addressed accesses to a RAM and a ROM
// region with byte lanes, alignment/region fault detection and programmable wait states.
module mem_bus_controller #(
  parameter int          DATA_WIDTH    = 64,
  parameter int          ADDR_WIDTH    = 32,
  parameter logic [31:0] RAM_BASE      = 32'h0002_0000,
  parameter int          RAM_ADDR_BITS = 10,
  parameter logic [31:0] ROM_BASE      = 32'h0000_0000,
  parameter int          ROM_ADDR_BITS = 10,
  parameter int          WAIT_STATES   = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  mem_bus_controller_if.slave      bus,
  output logic [RAM_ADDR_BITS-1:0] ram_addr,
  output logic [7:0]               ram_be,
  output logic                     ram_we,
  output logic                     ram_re,
  output logic [DATA_WIDTH-1:0]    ram_wdata,
  input  logic [DATA_WIDTH-1:0]    ram_rdata,
  output logic [ROM_ADDR_BITS-1:0] rom_addr,
  output logic                     rom_re,
  input  logic [DATA_WIDTH-1:0]    rom_rdata,
  output logic [1:0]               dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] RAM_LO = ADDR_WIDTH'(RAM_BASE);
  localparam logic [ADDR_WIDTH-1:0] ROM_LO = ADDR_WIDTH'(ROM_BASE);
  localparam logic [3:0]            WS     = 4'(WAIT_STATES);

  function automatic logic [7:0] size_be(input logic [1:0] size);
    case (size)
      2'b00:   return 8'h01;
      2'b01:   return 8'h03;
      2'b10:   return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [2:0] align_mask(input logic [1:0] size);
    case (size)
      2'b00:   return 3'b000;
      2'b01:   return 3'b001;
      2'b10:   return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] size_data(input logic [1:0] size);
    case (size)
      2'b00:   return DATA_WIDTH'(64'h0000_0000_0000_00FF);
      2'b01:   return DATA_WIDTH'(64'h0000_0000_0000_FFFF);
      2'b10:   return DATA_WIDTH'(64'h0000_0000_FFFF_FFFF);
      default: return DATA_WIDTH'(64'hFFFF_FFFF_FFFF_FFFF);
    endcase
  endfunction

  state_t                  state, state_next;
  logic [3:0]              cnt;
  logic                    accept, access_done;
  logic                    resp_fault_q;
  logic [DATA_WIDTH-1:0]   resp_rdata_q;

  // Attributes of the request in flight, captured on accept.
  logic [2:0]              lat_lane;
  logic [1:0]              lat_size;
  logic                    lat_write;
  logic                    lat_rom;

  // Request decode, evaluated only while idle.
  logic [ADDR_WIDTH-1:0]   ram_off, rom_off;
  logic [2:0]              lane;
  logic                    ram_hit, rom_hit, misaligned, req_any, req_fault;

  assign lane       = bus.req_addr[2:0];
  assign ram_off    = bus.req_addr - RAM_LO;
  assign rom_off    = bus.req_addr - ROM_LO;
  assign ram_hit    = (bus.req_addr >= RAM_LO) && ((ram_off >> (RAM_ADDR_BITS + 3)) == '0);
  assign rom_hit    = (bus.req_addr >= ROM_LO) && ((rom_off >> (ROM_ADDR_BITS + 3)) == '0);
  assign misaligned = |(lane & align_mask(bus.req_size));
  assign req_any    = bus.req_read | bus.req_write;
  // RAM wins overlaps, so any write that misses RAM is either to ROM or unmapped.
  assign req_fault  = (bus.req_read & bus.req_write) | misaligned |
                      ~(ram_hit | rom_hit) | (bus.req_write & ~ram_hit);

  // Read return path: shift the selected doubleword down to the addressed lane.
  logic [DATA_WIDTH-1:0]   rd_src, rd_shift, rd_data;
  assign rd_src   = lat_rom ? rom_rdata : ram_rdata;
  assign rd_shift = rd_src >> {lat_lane, 3'b000};
  assign rd_data  = rd_shift & size_data(lat_size);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    access_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_any) begin
          accept     = 1'b1;
          state_next = req_fault ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt == WS) begin
          access_done = 1'b1;
          state_next  = S_RESP;
        end
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt          <= '0;
      ram_addr     <= '0;
      ram_be       <= '0;
      ram_we       <= 1'b0;
      ram_re       <= 1'b0;
      ram_wdata    <= '0;
      rom_addr     <= '0;
      rom_re       <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_rdata_q <= '0;
      lat_lane     <= '0;
      lat_size     <= '0;
      lat_write    <= 1'b0;
      lat_rom      <= 1'b0;
    end else if (accept) begin
      cnt       <= '0;
      lat_lane  <= lane;
      lat_size  <= bus.req_size;
      lat_write <= bus.req_write;
      lat_rom   <= ~ram_hit;
      if (req_fault) begin
        resp_fault_q <= 1'b1;
        resp_rdata_q <= '0;
      end else if (ram_hit) begin
        ram_addr  <= ram_off[RAM_ADDR_BITS+2:3];
        ram_be    <= size_be(bus.req_size) << lane;
        ram_we    <= bus.req_write;
        ram_re    <= bus.req_read;
        ram_wdata <= bus.req_wdata << {lane, 3'b000};
      end else begin
        rom_addr <= rom_off[ROM_ADDR_BITS+2:3];
        rom_re   <= 1'b1;
      end
    end else if (state == S_ACCESS) begin
      if (access_done) begin
        ram_we       <= 1'b0;
        ram_re       <= 1'b0;
        rom_re       <= 1'b0;
        resp_fault_q <= 1'b0;
        resp_rdata_q <= lat_write ? '0 : rd_data;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  assign bus.req_ready  = (state == S_IDLE);
  assign bus.resp_valid = (state == S_RESP);
  assign bus.resp_fault = resp_fault_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign dbg_state      = state;

  a_strobe_excl: assert property (@(posedge clock) disable iff (!reset)
    !((ram_re || ram_we) && rom_re));
  a_rw_excl: assert property (@(posedge clock) disable iff (!reset)
    !(ram_re && ram_we));
  a_strobe_in_access: assert property (@(posedge clock) disable iff (!reset)
    (ram_re || ram_we || rom_re) |-> (state == S_ACCESS));
  a_resp_one_cycle: assert property (@(posedge clock) disable iff (!reset)
    (state == S_RESP) |=> (state == S_IDLE));
  a_cnt_range: assert property (@(posedge clock) disable iff (!reset)
    cnt <= WS);

endmodule
